button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 14 +
 rtl/debounce_cell.sv | 69 ++++++
 rtl/button_conditioner.sv | 28 ++
 tb/tb_button_conditioner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// button_pkg: shared button count, debounce state type and priority helper.
package button_pkg;
  localparam int NUM_BUTTONS = 5;
  typedef enum logic [1:0] {STABLE_LO, ARM_HI, STABLE_HI, ARM_LO} db_state_e;
  // One-hot of the highest set bit; the loop runs upward so the top bit wins.
  function automatic logic [NUM_BUTTONS-1:0] top_onehot(input logic [NUM_BUTTONS-1:0] v);
    top_onehot = '0;
    for (int i = 0; i < NUM_BUTTONS; i++)
      if (v[i]) begin
        top_onehot = '0;
        top_onehot[i] = 1'b1;
      end
  endfunction
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: synchronizer plus debounce FSM for one button.
module debounce_cell
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  db_state_e state;
  logic din, done;
  assign din = sync[1];
  assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
  // The cycle that enters ARM already counts as the first stable cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      state <= STABLE_LO;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LO: if (din) begin
          state <= ARM_HI;
          cnt   <= CW'(1);
        end
        STABLE_HI: if (!din) begin
          state <= ARM_LO;
          cnt   <= CW'(1);
        end
        ARM_HI:
          if (!din) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (done) begin
            state <= STABLE_HI;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b1;
          end else cnt <= cnt + 1'b1;
        ARM_LO:
          if (din) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (done) begin
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            fall  <= 1'b1;
          end else cnt <= cnt + 1'b1;
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
        end
      endcase
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounces the push-buttons and latches a one-hot speed selection.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic [NUM_BUTTONS-1:0] buttons
);
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_cell
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .rise (btn_press[i]),
      .fall (btn_release[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) buttons <= '0;
    else if (|btn_press) buttons <= top_onehot(btn_press);
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus with a queued scoreboard checked by a monitor.
module tb_button_conditioner;
  typedef struct {
    int         cyc;
    logic [4:0] press;
    logic [4:0] rel;
    logic [4:0] level;
  } ev_t;
  typedef struct {
    int         cyc;
    logic [4:0] val;
  } bev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] btn_raw = '0;
  logic [4:0] btn_level, btn_press, btn_release, buttons;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  ev_t evq[$];
  bev_t bq[$];
  logic [4:0] exp_level = '0;
  logic [4:0] prev_buttons = '0;

  button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .buttons    (buttons)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input int c, input logic [4:0] p, input logic [4:0] r);
    ev_t e;
    exp_level = (exp_level | p) & ~r;
    e.cyc = c; e.press = p; e.rel = r; e.level = exp_level;
    evq.push_back(e);
  endtask

  task automatic push_b(input int c, input logic [4:0] v);
    bev_t b;
    b.cyc = c; b.val = v;
    bq.push_back(b);
  endtask

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Press v (held 20 cycles) and release it; bchg says whether buttons should reload.
  task automatic tap(input logic [4:0] v, input logic [4:0] bnew, input bit bchg);
    int t;
    t = cyc;
    btn_raw = btn_raw | v;
    push_ev(t + 6, v, '0);
    if (bchg) push_b(t + 7, bnew);
    step(20);
    t = cyc;
    btn_raw = btn_raw & ~v;
    push_ev(t + 6, '0, v);
    step(12);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if ((btn_press | btn_release) != 0) begin
        checks++;
        if (evq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: cyc %0d press %b release %b", cyc, btn_press, btn_release);
        end else begin
          ev_t e;
          e = evq.pop_front();
          if (e.cyc != cyc || e.press !== btn_press || e.rel !== btn_release || e.level !== btn_level) begin
            errors++;
            $display("FAIL pulse: got cyc %0d press %b release %b level %b expected cyc %0d press %b release %b level %b",
                     cyc, btn_press, btn_release, btn_level, e.cyc, e.press, e.rel, e.level);
          end
        end
      end
      if (buttons !== prev_buttons) begin
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_buttons: cyc %0d got %b was %b", cyc, buttons, prev_buttons);
        end else begin
          bev_t b;
          b = bq.pop_front();
          if (b.cyc != cyc || b.val !== buttons) begin
            errors++;
            $display("FAIL buttons: got cyc %0d value %b expected cyc %0d value %b", cyc, buttons, b.cyc, b.val);
          end
        end
      end
    end
    prev_buttons = buttons;
  end

  initial begin
    int t;
    step(3);
    check("reset_level", btn_level, '0);
    check("reset_press", btn_press | btn_release, '0);
    check("reset_buttons", buttons, '0);
    rst_n = 1'b1;
    step(3);
    tap(5'b00001, 5'b00001, 1'b1);
    // Bounce 1,0,1,0 then hold: only the final rising edge counts.
    btn_raw[1] = 1'b1; step(1);
    btn_raw[1] = 1'b0; step(1);
    btn_raw[1] = 1'b1; step(1);
    btn_raw[1] = 1'b0; step(1);
    t = cyc;
    btn_raw[1] = 1'b1;
    push_ev(t + 6, 5'b00010, '0);
    push_b(t + 7, 5'b00010);
    step(20);
    t = cyc;
    btn_raw[1] = 1'b0;
    push_ev(t + 6, '0, 5'b00010);
    step(12);
    tap(5'b10100, 5'b10000, 1'b1);
    tap(5'b00100, 5'b00100, 1'b1);
    check("hold_after_release", buttons, 5'b00100);
    tap(5'b00100, 5'b00100, 1'b0);
    check("reselect_same", buttons, 5'b00100);
    // Reset two cycles into ARM_HI with button 3 held.
    btn_raw[3] = 1'b1;
    step(4);
    rst_n = 1'b0;
    step(1);
    check("midreset_level", btn_level, '0);
    check("midreset_pulses", btn_press | btn_release, '0);
    check("midreset_buttons", buttons, '0);
    step(2);
    t = cyc;
    rst_n = 1'b1;
    push_ev(t + 6, 5'b01000, '0);
    push_b(t + 7, 5'b01000);
    step(20);
    t = cyc;
    btn_raw[3] = 1'b0;
    push_ev(t + 6, '0, 5'b01000);
    step(12);
    // Speed steps through each button in turn.
    tap(5'b00001, 5'b00001, 1'b1);
    tap(5'b00010, 5'b00010, 1'b1);
    tap(5'b00100, 5'b00100, 1'b1);
    tap(5'b01000, 5'b01000, 1'b1);
    tap(5'b10000, 5'b10000, 1'b1);
    // Three stable cycles is one short of acceptance.
    btn_raw[0] = 1'b1; step(3);
    btn_raw[0] = 1'b0; step(12);
    check("short_glitch_level", btn_level, '0);
    check("short_glitch_buttons", buttons, 5'b10000);
    // Exactly four stable cycles is accepted.
    t = cyc;
    btn_raw[0] = 1'b1;
    push_ev(t + 6, 5'b00001, '0);
    push_b(t + 7, 5'b00001);
    step(4);
    btn_raw[0] = 1'b0;
    push_ev(t + 10, '0, 5'b00001);
    step(15);
    checks++;
    if (evq.size() != 0 || bq.size() != 0) begin
      errors++;
      $display("FAIL missing_events: pulses left %0d buttons left %0d expected 0 0", evq.size(), bq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
